// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: management register
// map, counter word field positions, sequencer state type and a priority helper.
package pll_reconfig_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_N      = 6'd3;
  localparam logic [5:0] ADDR_M      = 6'd4;
  localparam logic [5:0] ADDR_C      = 6'd5;

  localparam int CNT_LO_LSB     = 0;
  localparam int CNT_HI_LSB     = 8;
  localparam int CNT_BYPASS_BIT = 16;
  localparam int CNT_ODD_BIT    = 17;
  localparam int C_SEL_LSB      = 18;
  localparam int MAX_CLK        = 18;

  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_N, RD_N, WR_M, RD_M, WR_C, RD_C,
    WR_START, BLANK, LOCK_WAIT, FIN
  } state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [4:0] first_set(input logic [MAX_CLK-1:0] mask);
    logic [4:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CLK; i++) begin
      if (mask[i] && !found) begin
        idx   = 5'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// Lock supervision after a reconfiguration start: 2-FF synchroniser, blanking
// window, consecutive-lock stability counter and timeout; emits ok/fail pulses.
module pll_lock_monitor #(
  parameter int LOCK_BLANK   = 8,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic pll_locked,
  output logic waiting,
  output logic lock_ok,
  output logic lock_fail
);

  localparam int BW = $clog2(LOCK_BLANK + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  logic          sync1, locked_s;
  logic          blanking;
  logic [BW-1:0] blank_cnt;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] timeout_cnt;

  // Both pulses are evaluated in the cycle the count would reach its limit.
  assign lock_ok   = waiting && locked_s && (stable_cnt == SW'(LOCK_STABLE - 1));
  assign lock_fail = waiting && (timeout_cnt == TW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1       <= 1'b0;
      locked_s    <= 1'b0;
      blanking    <= 1'b0;
      waiting     <= 1'b0;
      blank_cnt   <= '0;
      stable_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
      if (start) begin
        blanking  <= 1'b1;
        waiting   <= 1'b0;
        blank_cnt <= '0;
      end else if (blanking) begin
        if (blank_cnt == BW'(LOCK_BLANK - 1)) begin
          blanking    <= 1'b0;
          waiting     <= 1'b1;
          stable_cnt  <= '0;
          timeout_cnt <= '0;
        end else begin
          blank_cnt <= blank_cnt + 1'b1;
        end
      end else if (waiting) begin
        if (lock_ok || lock_fail) begin
          waiting <= 1'b0;
        end else begin
          timeout_cnt <= timeout_cnt + 1'b1;
          stable_cnt  <= locked_s ? stable_cnt + 1'b1 : '0;
        end
      end
    end
  end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Avalon-MM sequencer that writes N, M and masked C counters to the PLL reconfig
// controller, starts it and supervises lock. Optional: PLL_RECONFIG_READBACK_EN.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_CLK      = 2,
  parameter int CNT_W        = 18,
  parameter int LOCK_BLANK   = 8,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CNT_W-1:0]         cfg_n,
  input  logic [CNT_W-1:0]         cfg_m,
  input  logic [NUM_CLK*CNT_W-1:0] cfg_c,
  input  logic [NUM_CLK-1:0]       cfg_c_mask,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [5:0]               mgmt_address,
  output logic [31:0]              mgmt_writedata,
  output logic                     mgmt_write,
  output logic                     mgmt_read,
  input  logic [31:0]              mgmt_readdata,
  input  logic                     mgmt_waitrequest,
  input  logic                     pll_locked
);

  state_t                   state, nx_state;
  logic [CNT_W-1:0]         n_q, m_q;
  logic [NUM_CLK*CNT_W-1:0] c_q;
  logic [NUM_CLK-1:0]       rem, rem_after, nx_rem;
  logic [4:0]               idx, nx_idx;
  logic [5:0]               nx_addr;
  logic [31:0]              nx_data;
  logic                     lock_start, lock_waiting, lock_ok, lock_fail;
  logic                     unused_rd;

  assign unused_rd  = ^mgmt_readdata;
  assign lock_start = (state == WR_START) && !mgmt_waitrequest;

  // Next write after the current one completes; the channel scan consumes one
  // mask bit per C write so there is no dead cycle between channels.
  always_comb begin
    rem_after = rem & ~(NUM_CLK'(1) << idx);
    nx_rem    = rem;
    nx_idx    = idx;
    nx_state  = WR_START;
    nx_addr   = ADDR_START;
    nx_data   = 32'd1;
    case (state)
      WR_MODE: begin
        nx_state = WR_N;
        nx_addr  = ADDR_N;
        nx_data  = 32'(n_q);
      end
      WR_N, RD_N: begin
        nx_state = WR_M;
        nx_addr  = ADDR_M;
        nx_data  = 32'(m_q);
      end
      WR_M, RD_M: begin
        if (rem != '0) begin
          nx_state = WR_C;
          nx_addr  = ADDR_C;
          nx_idx   = first_set(MAX_CLK'(rem));
        end
      end
      WR_C, RD_C: begin
        nx_rem = rem_after;
        if (rem_after != '0) begin
          nx_state = WR_C;
          nx_addr  = ADDR_C;
          nx_idx   = first_set(MAX_CLK'(rem_after));
        end
      end
      default: ;
    endcase
    if (nx_state == WR_C)
      nx_data = 32'({nx_idx, c_q[int'(nx_idx)*CNT_W +: CNT_W]});
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      cfg_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      n_q            <= '0;
      m_q            <= '0;
      c_q            <= '0;
      rem            <= '0;
      idx            <= '0;
`ifdef PLL_RECONFIG_READBACK_EN
      mgmt_read      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            n_q            <= cfg_n;
            m_q            <= cfg_m;
            c_q            <= cfg_c;
            rem            <= cfg_c_mask;
            cfg_ready      <= 1'b0;
            busy           <= 1'b1;
            err            <= 1'b0;
            mgmt_write     <= 1'b1;
            mgmt_address   <= ADDR_MODE;
            mgmt_writedata <= '0;
            state          <= WR_MODE;
          end
        end
`ifdef PLL_RECONFIG_READBACK_EN
        WR_N, WR_M, WR_C: begin
          if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            mgmt_read  <= 1'b1;
            state      <= (state == WR_N) ? RD_N : (state == WR_M) ? RD_M : RD_C;
          end
        end
        WR_MODE, RD_N, RD_M, RD_C: begin
          if (!mgmt_waitrequest) begin
            mgmt_read <= 1'b0;
            if (state != WR_MODE &&
                mgmt_readdata[CNT_W-1:0] != mgmt_writedata[CNT_W-1:0]) begin
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              mgmt_write     <= 1'b1;
              mgmt_address   <= nx_addr;
              mgmt_writedata <= nx_data;
              idx            <= nx_idx;
              rem            <= nx_rem;
              state          <= nx_state;
            end
          end
        end
`else
        WR_MODE, WR_N, WR_M, WR_C: begin
          if (!mgmt_waitrequest) begin
            mgmt_address   <= nx_addr;
            mgmt_writedata <= nx_data;
            idx            <= nx_idx;
            rem            <= nx_rem;
            state          <= nx_state;
          end
        end
`endif
        WR_START: begin
          if (!mgmt_waitrequest) begin
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            state          <= BLANK;
          end
        end
        BLANK, LOCK_WAIT: begin
          if (lock_ok || lock_fail) begin
            err   <= !lock_ok;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else if (lock_waiting) begin
            state <= LOCK_WAIT;
          end
        end
        FIN: begin
          done      <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef PLL_RECONFIG_READBACK_EN
  assign mgmt_read = 1'b0;
`endif

  pll_lock_monitor #(
    .LOCK_BLANK  (LOCK_BLANK),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_monitor (
    .clk       (clk),
    .resetn    (resetn),
    .start     (lock_start),
    .pll_locked(pll_locked),
    .waiting   (lock_waiting),
    .lock_ok   (lock_ok),
    .lock_fail (lock_fail)
  );

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed/randomised bench for pll_reconfig_seq: expected write list and lock
// outcome are derived from the register map and lock rules, not from the RTL.
module tb_pll_reconfig_seq;

  localparam int NUM_CLK = 2;
  localparam int CNT_W   = 18;
  localparam int LB      = 8;
  localparam int LS      = 16;
  localparam int TO      = 100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [17:0] cfg_n, cfg_m;
  logic [35:0] cfg_c;
  logic [1:0]  cfg_c_mask;
  logic        busy, done, err;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write, mgmt_read;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        pll_locked;

  int checks = 0;
  int errors = 0;

  typedef logic [37:0] wr_t;
  wr_t expq[$];

  always #10 clk = ~clk;

  pll_reconfig_seq #(
    .NUM_CLK     (NUM_CLK),
    .CNT_W       (CNT_W),
    .LOCK_BLANK  (LB),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_n           (cfg_n),
    .cfg_m           (cfg_m),
    .cfg_c           (cfg_c),
    .cfg_c_mask      (cfg_c_mask),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .mgmt_address    (mgmt_address),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_write      (mgmt_write),
    .mgmt_read       (mgmt_read),
    .mgmt_readdata   (mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked      (pll_locked)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles from the START-accept sample to the done sample. The logic sees
  // pll_locked two cycles late; success needs LS consecutive locked cycles
  // within the TO-cycle window after blanking, and wins a tie with timeout.
  function automatic int exp_done_k(input int lock_mode, input int g);
    int run;
    int r;
    bit s;
    run = 0;
    for (int j = 1; j <= TO; j++) begin
      r   = LB + j - 2;
      s   = (lock_mode == 0) || (lock_mode == 2 && r != g);
      run = s ? run + 1 : 0;
      if (run == LS) return LB + j + 1;
    end
    return LB + TO + 1;
  endfunction

  // lock_mode: 0 locked high, 1 locked low, 2 one-cycle low glitch in LOCK_WAIT
  task automatic run_txn(input string tag, input logic [17:0] n, input logic [17:0] m,
                         input logic [35:0] c, input logic [1:0] mask, input int max_stall,
                         input int lock_mode, input bit hold_valid, input bit abort_c);
    int t, rel, stall, unstable, bad, expk, g;
    bit in_w, finished;
    logic [5:0]  ha;
    logic [31:0] hd;
    g = LB + 5;
    rel = -1; stall = 0; unstable = 0; bad = 0; in_w = 0; finished = 0;
    ha = '0; hd = '0;
    expq.delete();
    expq.push_back({6'd0, 32'd0});
    expq.push_back({6'd3, 32'(n)});
    expq.push_back({6'd4, 32'(m)});
    for (int i = 0; i < NUM_CLK; i++)
      if (mask[i]) expq.push_back({6'd5, (32'(i) << 18) | 32'(c[i*18 +: 18])});
    expq.push_back({6'd2, 32'd1});
    expk = exp_done_k(lock_mode, g);
    pll_locked = (lock_mode != 1);

    @(negedge clk);
    cfg_n = n; cfg_m = m; cfg_c = c; cfg_c_mask = mask; cfg_valid = 1'b1;
    t = 0;
    while (!cfg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, ":ready_seen"}, 64'(cfg_ready), 64'd1);
    @(negedge clk);
    if (!hold_valid) cfg_valid = 1'b0;
    cfg_n = 18'($urandom); cfg_m = 18'($urandom);
    cfg_c = {4'($urandom), 32'($urandom)}; cfg_c_mask = 2'($urandom);
    check({tag, ":busy_after_accept"}, 64'({busy, cfg_ready}), 64'b10);

    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (rel >= 0) rel++;
      end
      if (lock_mode == 2) pll_locked = (rel != g);
      if (mgmt_read !== 1'b0) bad++;
      if (done) begin
        check({tag, ":err"}, 64'(err), 64'(lock_mode == 1));
        check({tag, ":done_latency"}, 64'(rel), 64'(expk));
        check({tag, ":busy_ready_at_done"}, 64'({busy, cfg_ready}), 64'b00);
        check({tag, ":write_count"}, 64'(expq.size()), 64'd0);
        finished = 1;
      end else begin
        if (!busy || cfg_ready) bad++;
        if (mgmt_write) begin
          if (abort_c && mgmt_address == 6'd5) begin
            resetn = 1'b0;
            @(negedge clk);
            check({tag, ":reset_mid_wr_c"},
                  64'({cfg_ready, busy, done, err, mgmt_write, mgmt_read,
                       mgmt_address, mgmt_writedata}), 64'd0);
            resetn = 1'b1; cfg_valid = 1'b0; mgmt_waitrequest = 1'b0;
            return;
          end
          if (!in_w) begin
            in_w = 1; ha = mgmt_address; hd = mgmt_writedata;
            stall = $urandom_range(0, max_stall);
            if (expq.size() == 0) begin
              check({tag, ":extra_write"}, 64'({mgmt_address, mgmt_writedata}), 64'd0);
            end else begin
              check({tag, ":addr"}, 64'(mgmt_address), 64'(expq[0][37:32]));
              check({tag, ":data"}, 64'(mgmt_writedata), 64'(expq[0][31:0]));
            end
          end else if (mgmt_address != ha || mgmt_writedata != hd) begin
            unstable++;
          end
          if (stall > 0) begin
            mgmt_waitrequest = 1'b1;
            stall--;
          end else begin
            mgmt_waitrequest = 1'b0;
            in_w = 0;
            if (expq.size() > 0) void'(expq.pop_front());
            if (ha == 6'd2) rel = 0;
          end
        end else begin
          mgmt_waitrequest = 1'($urandom_range(0, 1));
        end
      end
    end
    check({tag, ":done_within_budget"}, 64'(finished), 64'd1);
    check({tag, ":stall_stable"}, 64'(unstable), 64'd0);
    check({tag, ":busy_ready_read_ok"}, 64'(bad), 64'd0);
    cfg_valid = 1'b0;
    mgmt_waitrequest = 1'b0;
    @(negedge clk);
    check({tag, ":after_done"}, 64'({done, busy, cfg_ready, err}),
          64'({1'b0, 1'b0, 1'b1, 1'(lock_mode == 1)}));
    @(negedge clk);
    check({tag, ":no_requeue"}, 64'(busy), 64'd0);
  endtask

  initial begin
    resetn = 1'b0; cfg_valid = 1'b0; cfg_n = '0; cfg_m = '0; cfg_c = '0;
    cfg_c_mask = '0; mgmt_readdata = '0; mgmt_waitrequest = 1'b0; pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({cfg_ready, busy, done, err, mgmt_write, mgmt_read,
                                mgmt_address, mgmt_writedata}), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(cfg_ready), 64'd1);

    run_txn("vector", 18'h10000, 18'h00D0D, {18'h20706, 18'h00A0A}, 2'b11, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      run_txn("stalls", 18'($urandom), 18'($urandom), {4'($urandom), 32'($urandom)},
              2'($urandom), 5, 0, 0, 0);
    run_txn("timeout", 18'($urandom), 18'($urandom), {4'($urandom), 32'($urandom)},
            2'b10, 3, 1, 0, 0);
    run_txn("glitch", 18'($urandom), 18'($urandom), {4'($urandom), 32'($urandom)},
            2'b01, 2, 2, 0, 0);
    run_txn("hold_valid", 18'($urandom), 18'($urandom), {4'($urandom), 32'($urandom)},
            2'b00, 0, 0, 1, 0);
    run_txn("abort", 18'($urandom), 18'($urandom), {4'($urandom), 32'($urandom)},
            2'b11, 4, 0, 0, 1);
    run_txn("after_abort", 18'h10000, 18'h00D0D, {18'h20706, 18'h00A0A}, 2'b11, 2, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
Avalon-MM master sequencer that retunes a reconfigurable Cyclone V PLL (altera_pll_reconfig management port) at run time. It generalises the fixed two-output pixel/system clock PLL: it writes N, M and up to NUM_CLK C counters from a single config request, starts reconfiguration, then monitors lock with blanking, a stability window and a timeout. It sits between software/register logic and the PLL's reconfig controller, so output clock frequencies can change without a rebuild.

Parameters:
NUM_CLK, 2, number of C counters handled (1..18); C index = counter select
CNT_W, 18, packed counter word: [17] odd_duty, [16] bypass, [15:8] hi, [7:0] lo
LOCK_BLANK, 8, cycles after start accept during which locked is ignored
LOCK_STABLE, 16, consecutive synced-locked cycles required for success
LOCK_TIMEOUT, 65535, max cycles after blanking to reach stability

Ports:
clk  in  1  management clock; all logic on rising edge
resetn  in  1  synchronous, active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  high only in IDLE; transfer when cfg_valid&&cfg_ready
cfg_n  in  CNT_W  N counter word
cfg_m  in  CNT_W  M counter word
cfg_c  in  NUM_CLK*CNT_W  C counter words, channel i at [i*CNT_W +: CNT_W]
cfg_c_mask  in  NUM_CLK  1 = write channel i
busy  out  1  high from accept until done
done  out  1  one-cycle pulse at end of sequence
err  out  1  valid with done; 1 = lock timeout (or readback mismatch)
mgmt_address  out  6  reconfig register address
mgmt_writedata  out  32  write data
mgmt_write  out  1  write strobe
mgmt_read  out  1  read strobe (only with optional feature, else 0)
mgmt_readdata  in  32  read data
mgmt_waitrequest  in  1  stall
pll_locked  in  1  PLL locked, asynchronous

Behaviour:
- Reset: cfg_ready=0 in reset cycle then 1; busy=0, done=0, err=0, mgmt_write=0, mgmt_read=0, mgmt_address=0, mgmt_writedata=0; FSM=IDLE.
- Accept: latch cfg_* into internal regs; inputs ignored until next IDLE. cfg_valid while busy is neither accepted nor queued.
- States: IDLE -> WR_MODE (addr 0, data 0 = waitrequest mode) -> WR_N (addr 3, data {14'b0,cfg_n}) -> WR_M (addr 4) -> WR_C (addr 5, data {9'b0, idx[4:0], cfg_c[idx]}) for each set mask bit, ascending -> WR_START (addr 2, data 1) -> BLANK -> LOCK_WAIT -> FIN -> IDLE.
- Mask zero: WR_M goes directly to WR_START.
- Avalon write: mgmt_write, address and data asserted and held stable; the write completes in the cycle with mgmt_waitrequest=0, and the FSM advances on the next edge. Back-to-back writes are allowed without an idle cycle.
- Channel scan: priority search over the remaining mask, one channel per write, no dead cycles.
- pll_locked: 2-FF synchronised. BLANK lasts LOCK_BLANK cycles.
- LOCK_WAIT: the stable counter resets on any synced-locked=0. Success when the counter reaches LOCK_STABLE. A timeout counter (width $clog2(LOCK_TIMEOUT+1)) fails at LOCK_TIMEOUT cycles. If both happen in the same cycle, success wins.
- FIN: done=1 for one cycle, err set and held until next accept; busy falls the same cycle as done.
- Reset mid-operation: next edge forces reset values and abandons any pending Avalon write; no partial-sequence recovery.
- Min latency (mask=0b11, no stalls): 6 writes + LOCK_BLANK + LOCK_STABLE + 2 sync + 1.

Optional Feature:
PLL_RECONFIG_READBACK_EN
- Defined: after each N/M/C write, a read of the same address (C: select field written first). On mgmt_waitrequest=0, compare readdata[17:0] with the written word; mismatch sets err and jumps to FIN without START.
- Undefined: no reads, mgmt_read tied 0, mgmt_readdata unused.

Decomposition:
- Package pll_reconfig_pkg: register addresses (MODE=0, STATUS=1, START=2, N=3, M=4, C=5), counter field positions, state enum.
- Sub-module pll_lock_monitor: synchroniser, blank, stable and timeout counters; outputs lock_ok/lock_fail pulses.

Test Plan:
- 50 MHz ref, cfg_n=0x10000, cfg_m=0x00D0D, c0=0x00A0A, c1=0x20706, mask=0b11, locked high -> writes (0,0),(3,0x10000),(4,0x0D0D),(5,0x00A0A),(5,0x60706),(2,1); done with err=0.
- Random 0-5 cycle waitrequest stalls -> identical write order, address/data stable throughout each stall.
- LOCK_TIMEOUT=100, locked held 0 -> done with err=1 exactly at BLANK+100 cycles after START accept.
- Locked glitches low once in LOCK_WAIT -> success delayed by the stable-count restart, err=0.
- cfg_valid held high during busy, mask=0 -> single sequence, no C writes, cfg_ready=0 while busy.
- resetn low during WR_C -> all outputs at reset values next cycle; new request then completes normally.
